spike_decider: RTL and testbench

- Parametrised successor to the post-core output stage. Counts output-neuron spikes per image and finds the winning neuron by sequential argmax.
- In test mode, binds the supplied label to the winner. In classify mode, reports the winner's stored label.
- Sits after the SNN core; consumes per-time-unit output spike vectors and drives a valid/ready result interface.

---
 rtl/spike_decider.sv | 127 ++++++++++++
 tb/tb_spike_decider.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/spike_decider.sv
// Per-image output-spike counter with sequential argmax; binds test labels / reports classify labels. LABEL_LOCK_EN keeps first label.
// Latency done_img -> result_valid: N+2 cycles (test/classify), 1 cycle (train/idle).
// Backpressure: result held in DONE until result_ready; spike inputs ignored while busy.
module spike_decider #(
  parameter int              N     = 8,
  parameter int              CW    = 8,
  parameter int              LW    = 8,
  parameter int              IW    = 3,
  parameter logic [LW-1:0]   UNLAB = 8'hFF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    mode,
  input  logic [LW-1:0] test_label,
  input  logic          coring,
  input  logic [N-1:0]  ops,
  input  logic          tu_incre,
  input  logic          done_img,
  input  logic          result_ready,
  output logic          busy,
  output logic          result_valid,
  output logic [LW-1:0] image_label,
  output logic [IW-1:0] winner_idx,
  output logic [CW-1:0] winner_count,
  output logic          no_spike
);

  typedef enum logic [1:0] {COUNT, SCAN, APPLY, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt [N];
  logic [LW-1:0] lbl_tab [N];
  logic [N-1:0]  lbl_vld;
  logic [1:0]    mode_q;
  logic [IW-1:0] scan_idx;
  logic [IW-1:0] max_idx;
  logic [CW-1:0] max_cnt;
  logic          tu_fire;
  logic          img_end;
  logic          handshake;

  assign tu_fire      = (state == COUNT) && coring && tu_incre;
  assign img_end      = tu_fire && done_img;
  assign handshake    = (state == DONE) && result_ready;
  assign busy         = (state != COUNT);
  assign result_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COUNT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COUNT: if (img_end) state_nxt = mode[1] ? SCAN : DONE;
      SCAN:  if (scan_idx == IW'(N-1)) state_nxt = APPLY;
      APPLY: state_nxt = DONE;
      DONE:  if (result_ready) state_nxt = COUNT;
      default: state_nxt = COUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (handshake)
          cnt[i] <= '0;
        else if (tu_fire && ops[i] && (cnt[i] != {CW{1'b1}}))
          cnt[i] <= cnt[i] + CW'(1);
      end
    end
  end

  // Running argmax; strict '>' keeps the lowest index on ties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= 2'b00;
      scan_idx <= '0;
      max_idx  <= '0;
      max_cnt  <= '0;
    end else if (img_end) begin
      mode_q   <= mode;
      scan_idx <= '0;
      max_idx  <= '0;
      max_cnt  <= '0;
    end else if (state == SCAN) begin
      scan_idx <= scan_idx + IW'(1);
      if (cnt[scan_idx] > max_cnt) begin
        max_cnt <= cnt[scan_idx];
        max_idx <= scan_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      winner_idx   <= '0;
      winner_count <= '0;
      no_spike     <= 1'b0;
      image_label  <= '0;
      lbl_vld      <= '0;
      for (int i = 0; i < N; i++) lbl_tab[i] <= UNLAB;
    end else if (img_end && !mode[1]) begin
      winner_idx   <= '0;
      winner_count <= '0;
      no_spike     <= 1'b0;
    end else if (state == APPLY) begin
      winner_idx   <= max_idx;
      winner_count <= max_cnt;
      no_spike     <= (max_cnt == '0);
      if (mode_q == 2'b10 && max_cnt != '0) begin
`ifdef LABEL_LOCK_EN
        if (!lbl_vld[max_idx]) lbl_tab[max_idx] <= test_label;
`else
        lbl_tab[max_idx] <= test_label;
`endif
        lbl_vld[max_idx] <= 1'b1;
      end
      if (mode_q == 2'b11)
        image_label <= (lbl_vld[max_idx] && max_cnt != '0) ? lbl_tab[max_idx] : UNLAB;
    end
  end

endmodule

// File: tb/tb_spike_decider.sv
// Randomised and directed bench for spike_decider against an array-based reference model.
module tb_spike_decider;
  localparam int            N     = 8;
  localparam int            CW    = 4;
  localparam int            LW    = 8;
  localparam int            IW    = 3;
  localparam int            CMAX  = 15;
  localparam logic [LW-1:0] UNLAB = 8'hFF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [LW-1:0] test_label = '0;
  logic          coring = 1'b0;
  logic [N-1:0]  ops = '0;
  logic          tu_incre = 1'b0;
  logic          done_img = 1'b0;
  logic          result_ready = 1'b0;
  logic          busy;
  logic          result_valid;
  logic [LW-1:0] image_label;
  logic [IW-1:0] winner_idx;
  logic [CW-1:0] winner_count;
  logic          no_spike;

  always #5 clk = ~clk;

  spike_decider #(.N(N), .CW(CW), .LW(LW), .IW(IW), .UNLAB(UNLAB)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .test_label(test_label),
    .coring(coring), .ops(ops), .tu_incre(tu_incre), .done_img(done_img),
    .result_ready(result_ready), .busy(busy), .result_valid(result_valid),
    .image_label(image_label), .winner_idx(winner_idx),
    .winner_count(winner_count), .no_spike(no_spike)
  );

  int passed = 0;
  int total  = 0;

  // Reference model state
  int            m_cnt [N];
  logic [LW-1:0] m_tab [N];
  bit            m_vld [N];
  logic [LW-1:0] m_label;
  int            e_idx, e_cnt;
  bit            e_nos;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0;
      m_tab[i] = UNLAB;
      m_vld[i] = 1'b0;
    end
    m_label = '0;
  endtask

  task automatic idle_inputs();
    coring = 1'b0; tu_incre = 1'b0; done_img = 1'b0; ops = '0; result_ready = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, result_valid, 1);
    check({tag, ".idx"},   winner_idx, e_idx);
    check({tag, ".count"}, winner_count, e_cnt);
    check({tag, ".nospk"}, no_spike, e_nos);
    check({tag, ".label"}, image_label, m_label);
  endtask

  // Feed one image; then keep driving junk spikes while the block is busy.
  task automatic run_image(input string tag, input logic [1:0] m, input logic [LW-1:0] lbl,
                           input int ntu, input bit rnd, input logic [N-1:0] fixed);
    logic [N-1:0] v;
    int lat, best, bi;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    for (int t = 0; t < ntu; t++) begin
      v = rnd ? N'($urandom_range(0, 255)) : fixed;
      mode = m; test_label = lbl; coring = 1'b1; tu_incre = 1'b1; ops = v;
      done_img = (t == ntu - 1);
      for (int i = 0; i < N; i++) if (v[i] && m_cnt[i] < CMAX) m_cnt[i]++;
      @(posedge clk); #1;
    end
    lat = 1;
    while (!result_valid && lat < 4 * N) begin
      ops = N'($urandom_range(0, 255)); done_img = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
    end
    if (m[1]) begin
      best = 0; bi = 0;
      for (int i = 0; i < N; i++) if (m_cnt[i] > best) begin best = m_cnt[i]; bi = i; end
      e_idx = bi; e_cnt = best; e_nos = (best == 0);
      if (m == 2'b10 && !e_nos) begin
`ifdef LABEL_LOCK_EN
        if (!m_vld[bi]) m_tab[bi] = lbl;
`else
        m_tab[bi] = lbl;
`endif
        m_vld[bi] = 1'b1;
      end
      if (m == 2'b11) m_label = (m_vld[bi] && !e_nos) ? m_tab[bi] : UNLAB;
    end else begin
      e_idx = 0; e_cnt = 0; e_nos = 1'b0;
    end
    check({tag, ".lat"}, lat, m[1] ? N + 2 : 1);
    check({tag, ".busy"}, busy, 1);
    check_outputs(tag);
  endtask

  // Hold result_ready low for 'hold' cycles with junk spikes, then accept.
  task automatic handshake(input string tag, input int hold);
    for (int h = 0; h < hold; h++) begin
      coring = 1'b1; tu_incre = 1'b1; ops = N'($urandom_range(0, 255));
      done_img = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check_outputs({tag, ".hold"});
    end
    result_ready = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
    check({tag, ".rv_drop"}, result_valid, 0);
    check({tag, ".idle"}, busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".rv"},    result_valid, 0);
    check({tag, ".busy"},  busy, 0);
    check({tag, ".label"}, image_label, 0);
    check({tag, ".idx"},   winner_idx, 0);
    check({tag, ".count"}, winner_count, 0);
    check({tag, ".nospk"}, no_spike, 0);
  endtask

  initial begin
    logic [1:0]    rm;
    logic [LW-1:0] lock_exp;
    model_reset();
    #12;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_image("test5", 2'b10, 8'd5, 10, 1'b0, 8'b0000_0100);
    handshake("test5", 0);
    run_image("cls5", 2'b11, 8'd0, 10, 1'b0, 8'b0000_0100);
    check("cls5.direct", image_label, 5);
    handshake("cls5", 1);
    run_image("cls_unl", 2'b11, 8'd0, 3, 1'b0, 8'b0000_1000);
    check("cls_unl.direct", image_label, UNLAB);
    handshake("cls_unl", 0);

    run_image("tie", 2'b10, 8'd9, 4, 1'b0, 8'b0100_0010);
    check("tie.direct", winner_idx, 1);
    handshake("tie", 0);
    run_image("zero", 2'b10, 8'd3, 6, 1'b0, 8'b0000_0000);
    handshake("zero", 0);
    run_image("cls_n0", 2'b11, 8'd0, 2, 1'b0, 8'b0000_0001);
    check("cls_n0.direct", image_label, UNLAB);
    handshake("cls_n0", 0);

    run_image("sat", 2'b11, 8'd0, 20, 1'b0, 8'b0000_0001);
    check("sat.direct", winner_count, 15);
    handshake("sat", 5);

    run_image("train", 2'b01, 8'd0, 6, 1'b1, '0);
    handshake("train", 2);

    // done_img without the time-unit strobe must not end an image
    coring = 1'b1; tu_incre = 1'b0; done_img = 1'b1; ops = '1;
    @(posedge clk); #1;
    check("stray_done.a", busy, 0);
    coring = 1'b0; tu_incre = 1'b1;
    @(posedge clk); #1;
    check("stray_done.b", busy, 0);
    idle_inputs();

    for (int k = 0; k < 12; k++) begin
      rm = 2'($urandom_range(0, 3));
      run_image("rand", rm, LW'($urandom_range(0, 254)), $urandom_range(1, 22), 1'b1, '0);
      handshake("rand", $urandom_range(0, 3));
    end

    // Reset in the middle of a scan
    mode = 2'b10; test_label = 8'd4; coring = 1'b1; tu_incre = 1'b1; ops = 8'b0000_0100;
    done_img = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    check("midscan.busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midscan_rst");
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_image("post_rst", 2'b11, 8'd0, 2, 1'b0, 8'b0000_0100);
    check("post_rst.direct", image_label, UNLAB);
    handshake("post_rst", 0);

    run_image("lock5", 2'b10, 8'd5, 3, 1'b0, 8'b0000_0100);
    handshake("lock5", 0);
    run_image("lock7", 2'b10, 8'd7, 3, 1'b0, 8'b0000_0100);
    handshake("lock7", 0);
    run_image("lock_cls", 2'b11, 8'd0, 3, 1'b0, 8'b0000_0100);
`ifdef LABEL_LOCK_EN
    lock_exp = 8'd5;
`else
    lock_exp = 8'd7;
`endif
    check("lock_cls.direct", image_label, lock_exp);
    handshake("lock_cls", 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
